// File: rtl/sm_trace_buffer.sv
// Circular execution-trace buffer for schoolMIPS: keeps the last DEPTH retired
// {pc, instr} pairs plus a step counter, self-loop halt detection and a timeout.
module sm_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 120,
  parameter int HALT_REPEAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             clear,
  input  logic [AW-1:0]    readIdx,
  output logic [31:0]      readPc,
  output logic [31:0]      readInstr,
  output logic             readValid,
  output logic [AW:0]      entries,
  output logic [CNT_W-1:0] stepCount,
  output logic             halted,
  output logic             timedOut
);

  localparam int RW = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {RUN, HALT, TOUT} stateT;

  stateT            state, stateNext;
  logic [AW-1:0]    wrPtr;
  logic [RW-1:0]    repCnt, repNext;
  logic [31:0]      lastPc;
  logic [CNT_W-1:0] countNext;
  logic [63:0]      mem [DEPTH];
  logic [63:0]      readData;
  logic [AW-1:0]    rdAddr;
  logic             rdHit;
  logic             capture;

  assign capture   = step && !clear && (state == RUN);
  // repCnt == 0 marks "no step since reset/clear", so lastPc is not trusted then
  assign repNext   = (repCnt != '0 && pc == lastPc) ? repCnt + RW'(1) : RW'(1);
  assign countNext = (&stepCount) ? stepCount : stepCount + CNT_W'(1);
  assign rdAddr    = wrPtr - AW'(1) - readIdx;
  assign rdHit     = {1'b0, readIdx} < entries;

  assign halted    = (state == HALT);
  assign timedOut  = (state == TOUT);
  assign readPc    = readData[63:32];
  assign readInstr = readData[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= stateNext;
  end

  // Halt takes priority when both conditions fire on the same step
  always_comb begin
    stateNext = state;
    if (clear) begin
      stateNext = RUN;
    end else if (capture) begin
      if (repNext == RW'(HALT_REPEAT))
        stateNext = HALT;
      else if (TIMEOUT != 0 && countNext == CNT_W'(TIMEOUT))
        stateNext = TOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      entries   <= '0;
      stepCount <= '0;
      repCnt    <= '0;
      lastPc    <= '0;
    end else if (clear) begin
      wrPtr     <= '0;
      entries   <= '0;
      stepCount <= '0;
      repCnt    <= '0;
    end else if (capture) begin
      wrPtr     <= wrPtr + AW'(1);
      entries   <= (entries == (AW+1)'(DEPTH)) ? entries : entries + (AW+1)'(1);
      stepCount <= countNext;
      repCnt    <= repNext;
      lastPc    <= pc;
    end
  end

  // Unreset storage so it maps onto block RAM; old data is hidden by entries
  always_ff @(posedge clk) begin
    if (capture) mem[wrPtr] <= {pc, instr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readData  <= '0;
      readValid <= 1'b0;
    end else begin
      readData  <= rdHit ? mem[rdAddr] : '0;
      readValid <= rdHit;
    end
  end

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Bench for sm_trace_buffer: directed scenarios plus random traffic checked
// against a queue-based history model of every captured step.
module tb_sm_trace_buffer;

  localparam int DEPTH       = 16;
  localparam int AW          = 4;
  localparam int TIMEOUT     = 120;
  localparam int HALT_REPEAT = 4;

  logic          clk, rst_n, step, clear;
  logic [31:0]   pc, instr;
  logic [AW-1:0] readIdx;
  logic [31:0]   readPc, readInstr;
  logic          readValid, halted, timedOut;
  logic [AW:0]   entries;
  logic [31:0]   stepCount;

  int total = 0;
  int bad   = 0;

  logic [63:0] hist[$];
  bit mHalt, mTout;

  sm_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .CNT_W(32), .TIMEOUT(TIMEOUT),
                    .HALT_REPEAT(HALT_REPEAT)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .pc(pc), .instr(instr),
    .clear(clear), .readIdx(readIdx), .readPc(readPc), .readInstr(readInstr),
    .readValid(readValid), .entries(entries), .stepCount(stepCount),
    .halted(halted), .timedOut(timedOut));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int mEntries();
    return (hist.size() < DEPTH) ? hist.size() : DEPTH;
  endfunction

  function automatic logic [64:0] expRead(int idx);
    if (idx < mEntries()) return {1'b1, hist[hist.size()-1-idx]};
    return 65'd0;
  endfunction

  function automatic void modelClear();
    hist.delete();
    mHalt = 0;
    mTout = 0;
  endfunction

  function automatic void modelStep(logic [31:0] p, logic [31:0] ins);
    int run;
    int i;
    logic [63:0] e;
    if (mHalt || mTout) return;
    hist.push_back({p, ins});
    run = 0;
    i = hist.size() - 1;
    while (i >= 0) begin
      e = hist[i];
      if (e[63:32] != p) break;
      run++;
      i--;
    end
    if (run >= HALT_REPEAT) mHalt = 1;
    else if (TIMEOUT != 0 && hist.size() == TIMEOUT) mTout = 1;
  endfunction

  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] ins);
    step = 1; pc = p; instr = ins;
    @(posedge clk); #1;
    step = 0;
    modelStep(p, ins);
  endtask

  task automatic doClear(input bit withStep, input logic [31:0] p);
    clear = 1; step = withStep; pc = p; instr = ~p;
    @(posedge clk); #1;
    clear = 0; step = 0;
    modelClear();
  endtask

  task automatic doRead(input int idx);
    readIdx = AW'(idx);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; step = 0; clear = 0; pc = 0; instr = 0; readIdx = 0;
    modelClear();
    #12;
    total++;
    if ({readPc, readInstr, readValid} !== 65'd0 || entries !== '0 ||
        stepCount !== 32'd0 || halted !== 1'b0 || timedOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset: pc=%h instr=%h v=%b ent=%0d cnt=%0d h=%b t=%b required all 0",
               readPc, readInstr, readValid, entries, stepCount, halted, timedOut);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [64:0] e;
    applyStimulus(0, 32'hA);
    applyStimulus(1, 32'hB);
    applyStimulus(2, 32'hC);
    total++;
    if (entries !== 5'd3 || stepCount !== 32'd3) begin
      bad++;
      $display("[TB] FAIL basic_count: ent=%0d cnt=%0d required 3/3", entries, stepCount);
    end
    for (int i = 0; i < 4; i++) begin
      e = expRead(i);
      doRead(i);
      total++;
      if ({readValid, readPc, readInstr} !== e) begin
        bad++;
        $display("[TB] FAIL basic_read%0d: got %b/%h/%h required %b/%h/%h", i,
                 readValid, readPc, readInstr, e[64], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [64:0] e;
    doClear(0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(i, $urandom);
    total++;
    if (entries !== 5'd16 || stepCount !== 32'd20) begin
      bad++;
      $display("[TB] FAIL wrap_count: ent=%0d cnt=%0d required 16/20", entries, stepCount);
    end
    for (int i = 0; i < DEPTH; i++) begin
      e = expRead(i);
      doRead(i);
      total++;
      if ({readValid, readPc, readInstr} !== e || readPc !== 32'(19 - i)) begin
        bad++;
        $display("[TB] FAIL wrap_read%0d: got %b/%h/%h required %b/%h/%h", i,
                 readValid, readPc, readInstr, e[64], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_halt();
    logic [64:0] e;
    doClear(0, 0);
    applyStimulus(5, 1); applyStimulus(6, 2);
    applyStimulus(7, 3); applyStimulus(7, 4); applyStimulus(7, 5);
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("[TB] FAIL halt_early: halted=%b required 0", halted);
    end
    applyStimulus(7, 6);
    total++;
    if (halted !== 1'b1 || timedOut !== 1'b0 || entries !== 5'd6) begin
      bad++;
      $display("[TB] FAIL halt_set: h=%b t=%b ent=%0d required 1/0/6", halted, timedOut, entries);
    end
    applyStimulus(8, 7); applyStimulus(9, 8);
    total++;
    if (entries !== 5'd6 || stepCount !== 32'd6 || halted !== 1'b1) begin
      bad++;
      $display("[TB] FAIL halt_frozen: ent=%0d cnt=%0d h=%b required 6/6/1", entries, stepCount, halted);
    end
    e = expRead(0);
    doRead(0);
    total++;
    if ({readValid, readPc, readInstr} !== e) begin
      bad++;
      $display("[TB] FAIL halt_read: got %h/%h required %h/%h", readPc, readInstr, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_timeout();
    logic [64:0] e;
    doClear(0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(100 + i, $urandom);
    total++;
    if (timedOut !== 1'b0 || stepCount !== 32'(TIMEOUT - 1)) begin
      bad++;
      $display("[TB] FAIL tout_early: t=%b cnt=%0d required 0/%0d", timedOut, stepCount, TIMEOUT - 1);
    end
    applyStimulus(100 + TIMEOUT - 1, $urandom);
    total++;
    if (timedOut !== 1'b1 || halted !== 1'b0 || stepCount !== 32'(TIMEOUT)) begin
      bad++;
      $display("[TB] FAIL tout_set: t=%b h=%b cnt=%0d required 1/0/%0d", timedOut, halted, stepCount, TIMEOUT);
    end
    applyStimulus(999, 32'hDEAD);
    e = expRead(0);
    doRead(0);
    total++;
    if (stepCount !== 32'(TIMEOUT) || {readValid, readPc, readInstr} !== e) begin
      bad++;
      $display("[TB] FAIL tout_frozen: cnt=%0d pc=%h required %0d/%h", stepCount, readPc, TIMEOUT, e[63:32]);
    end
  endtask

  task automatic test_halt_and_timeout();
    doClear(0, 0);
    for (int i = 0; i < TIMEOUT - HALT_REPEAT; i++) applyStimulus(1000 + i, $urandom);
    for (int i = 0; i < HALT_REPEAT; i++) applyStimulus(5, $urandom);
    total++;
    if (halted !== 1'b1 || timedOut !== 1'b0 || stepCount !== 32'(TIMEOUT)) begin
      bad++;
      $display("[TB] FAIL both: h=%b t=%b cnt=%0d required 1/0/%0d", halted, timedOut, stepCount, TIMEOUT);
    end
  endtask

  task automatic test_clear_with_step();
    logic [64:0] e;
    doClear(1, 77);
    total++;
    if (entries !== '0 || stepCount !== 32'd0 || halted !== 1'b0 || timedOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear: ent=%0d cnt=%0d h=%b t=%b required 0s", entries, stepCount, halted, timedOut);
    end
    doRead(0);
    total++;
    if (readValid !== 1'b0 || readPc !== 32'd0) begin
      bad++;
      $display("[TB] FAIL clear_read: v=%b pc=%h required 0/0", readValid, readPc);
    end
    applyStimulus(3, 32'h33);
    e = expRead(0);
    doRead(0);
    total++;
    if (entries !== 5'd1 || {readValid, readPc, readInstr} !== e || readPc !== 32'd3) begin
      bad++;
      $display("[TB] FAIL clear_resume: ent=%0d pc=%h required 1/%h", entries, readPc, e[63:32]);
    end
  endtask

  task automatic test_async_reset();
    logic [64:0] e;
    doClear(0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(40 + i, $urandom);
    doRead(0);
    step = 1; pc = 50; instr = 32'h5050;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    total++;
    if ({readPc, readInstr, readValid} !== 65'd0 || entries !== '0 ||
        stepCount !== 32'd0 || halted !== 1'b0 || timedOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset: pc=%h v=%b ent=%0d cnt=%0d required 0s",
               readPc, readValid, entries, stepCount);
    end
    step = 0;
    modelClear();
    #1 rst_n = 1;
    @(posedge clk); #1;
    applyStimulus(60, 32'h6); applyStimulus(61, 32'h7);
    e = expRead(1);
    doRead(1);
    total++;
    if (entries !== 5'd2 || stepCount !== 32'd2 || {readValid, readPc, readInstr} !== e) begin
      bad++;
      $display("[TB] FAIL async_resume: ent=%0d cnt=%0d pc=%h required 2/2/%h",
               entries, stepCount, readPc, e[63:32]);
    end
  endtask

  task automatic test_random();
    logic [64:0] e;
    bit clr, st;
    logic [31:0] p, ins;
    int idx;
    doClear(0, 0);
    for (int n = 0; n < 300; n++) begin
      clr = ($urandom_range(0, 24) == 0);
      st  = ($urandom_range(0, 3) != 0);
      p   = $urandom_range(0, 2);
      ins = $urandom;
      idx = $urandom_range(0, DEPTH - 1);
      e   = expRead(idx);
      clear = clr; step = st; pc = p; instr = ins; readIdx = AW'(idx);
      @(posedge clk); #1;
      clear = 0; step = 0;
      if (clr) modelClear();
      else if (st) modelStep(p, ins);
      total++;
      if ({readValid, readPc, readInstr} !== e || entries !== (AW+1)'(mEntries()) ||
          stepCount !== 32'(hist.size()) || halted !== mHalt || timedOut !== mTout) begin
        bad++;
        $display("[TB] FAIL random%0d: rd=%b/%h/%h ent=%0d cnt=%0d h=%b t=%b required rd=%b/%h/%h ent=%0d cnt=%0d h=%b t=%b",
                 n, readValid, readPc, readInstr, entries, stepCount, halted, timedOut,
                 e[64], e[63:32], e[31:0], mEntries(), hist.size(), mHalt, mTout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_halt();
    test_timeout();
    test_halt_and_timeout();
    test_clear_with_step();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
